// File: rtl/mccpu_mem_resp.sv
// ---------------------------------------------------------------------------
// mccpu_mem_resp
//
// Memory responder at the far end of the multi-cycle CPU memory port. It
// serves instruction fetches and data loads/stores from a word-addressed RAM,
// inserting LATENCY wait cycles before a one-cycle ready pulse. The CPU
// controller stalls on ready instead of assuming single-cycle memory.
//
// Handshake: the initiator raises req with we/addr/wdata and holds all of
// them stable until ready. The request is accepted on the first rising edge
// that sees req=1 while the responder is idle. ready is a single-cycle pulse;
// err and rdata are only meaningful while ready=1 (both are 0 otherwise).
// A req still high during the ready cycle is not a new request; it is
// re-sampled in idle on the following cycle, so back-to-back transactions
// take LATENCY+2 cycles each.
//
// Parameters
//   ADDR_WIDTH  word-address bits, RAM depth = 2**ADDR_WIDTH 32-bit words
//   LATENCY     wait cycles before ready (0..15)
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-low reset
//   req        in   1   request valid
//   we         in   1   1 = store word, 0 = load word
//   addr       in   32  byte address
//   wdata      in   32  store data
//   rdata      out  32  load data, valid with ready
//   ready      out  1   one-cycle completion pulse
//   err        out  1   with ready: request misaligned or out of range
//   busy       out  1   transaction accepted and not yet completed
//   dbg_state  out  2   current FSM state (0 idle, 1 wait, 2 resp)
// ---------------------------------------------------------------------------
module mccpu_mem_resp #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Elaboration-time parameter checks.
  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("mccpu_mem_resp: LATENCY must be in 0..15");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 28) begin : g_bad_addr_width
    $error("mccpu_mem_resp: ADDR_WIDTH must be in 1..28");
  end

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Wait counter is loaded with LATENCY-1 so the wait state lasts exactly
  // LATENCY cycles (it leaves on the edge where it reads zero).
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;

  // Request fields captured at acceptance.
  logic                  we_lat;
  logic                  err_lat;
  logic [ADDR_WIDTH-1:0] idx_lat;
  logic [31:0]           wdata_lat;

  logic [31:0] mem [0:DEPTH-1];

  // Decode of the live request.
  logic                  in_err;
  logic [ADDR_WIDTH-1:0] in_idx;

  assign in_idx = addr[ADDR_WIDTH+1:2];
  assign in_err = (addr[1:0] != 2'b00) || ((addr >> (ADDR_WIDTH + 2)) != 32'd0);

  // With LATENCY=0 the response is produced on the acceptance edge itself,
  // before the latches hold the request, so the live inputs are used while
  // idle and the latched copy afterwards.
  logic                  cur_we;
  logic                  cur_err;
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic [31:0]           cur_wdata;

  assign cur_we    = (state == S_IDLE) ? we     : we_lat;
  assign cur_err   = (state == S_IDLE) ? in_err : err_lat;
  assign cur_idx   = (state == S_IDLE) ? in_idx : idx_lat;
  assign cur_wdata = (state == S_IDLE) ? wdata  : wdata_lat;

  logic        accept;
  logic        enter_resp;
  logic        mem_wr;
  logic [31:0] rdata_next;

  // Next-state logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_next = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = S_WAIT;
            cnt_next   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_next = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Storage is touched only on the edge entering the response state, and
  // never for an erroneous request. Reset forces the state to idle, which
  // drops enter_resp, so an aborted store cannot reach the RAM.
  assign mem_wr     = enter_resp && cur_we && !cur_err;
  assign rdata_next = (enter_resp && !cur_we && !cur_err) ? mem[cur_idx] : 32'd0;

  // FSM state, wait counter and request latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      we_lat    <= 1'b0;
      err_lat   <= 1'b0;
      idx_lat   <= '0;
      wdata_lat <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        we_lat    <= we;
        err_lat   <= in_err;
        idx_lat   <= in_idx;
        wdata_lat <= wdata;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'd0;
      busy  <= 1'b0;
    end else begin
      ready <= enter_resp;
      err   <= enter_resp && cur_err;
      rdata <= rdata_next;
      busy  <= (state_next != S_IDLE);
    end
  end

  // RAM array: no reset, contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mccpu_mem_resp.sv
module tb_mccpu_mem_resp;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // LATENCY=2 instance
  logic        req2, we2;
  logic [31:0] addr2, wdata2, rdata2;
  logic        ready2, err2, busy2;
  logic [1:0]  st2;

  // LATENCY=0 instance
  logic        req0, we0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ready0, err0, busy0;
  logic [1:0]  st0;

  mccpu_mem_resp #(.ADDR_WIDTH(8), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .rdata(rdata2), .ready(ready2), .err(err2), .busy(busy2), .dbg_state(st2)
  );

  mccpu_mem_resp #(.ADDR_WIDTH(8), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0), .dbg_state(st0)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        scramble;   // disturb inputs while waiting
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  // ---------------------------------------------------------------- driver
  // One transaction on the LATENCY=2 instance. Checks busy while waiting,
  // the acceptance-to-ready distance (3 cycles), ready data and err, and
  // that ready is a single-cycle pulse.
  task automatic run_txn(input string name, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic scr,
                         input logic [31:0] exp_rd, input logic exp_e);
    int  cyc;
    bit  seen;
    logic [31:0] exp_v;
    exp_q.push_back(exp_rd);
    @(negedge clk);
    req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d;
    @(posedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (scr && cyc == 1) begin
        we2 = ~w; addr2 = a ^ 32'h4; wdata2 = ~d;
      end
      if (ready2) seen = 1'b1;
      else check({name, " busy_wait"}, {31'd0, busy2}, 32'd1);
    end
    req2 = 1'b0;
    exp_v = exp_q.pop_front();
    check({name, " ready_seen"}, {31'd0, seen}, 32'd1);
    check({name, " latency"}, cyc, 32'd3);
    check({name, " rdata"}, rdata2, exp_v);
    check({name, " err"}, {31'd0, err2}, {31'd0, exp_e});
    check({name, " busy_resp"}, {31'd0, busy2}, 32'd1);
    @(negedge clk);
    check({name, " ready_pulse"}, {31'd0, ready2}, 32'd0);
    check({name, " err_off"}, {31'd0, err2}, 32'd0);
    check({name, " busy_off"}, {31'd0, busy2}, 32'd0);
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    req2 = 0; we2 = 0; addr2 = 0; wdata2 = 0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;

    //                 we    addr          wdata          scr   exp_rdata     err
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0012, 32'h1111_1111, 1'b0, 32'h0000_0000, 1'b1};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0400, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b1, 32'h0000_03FC, 32'hA5A5_0001, 1'b0, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 1'b0, 32'hA5A5_0001, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 1'b1, 32'h1234_5678, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0030, 32'h0BAD_F00D, 1'b1, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0030, 32'h0000_0000, 1'b0, 32'h0BAD_F00D, 1'b0};
    vecs[11] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1};

    // Reset state, checked while reset is held.
    repeat (2) @(negedge clk);
    check("rst ready2", {31'd0, ready2}, 32'd0);
    check("rst err2",   {31'd0, err2},   32'd0);
    check("rst rdata2", rdata2,          32'd0);
    check("rst busy2",  {31'd0, busy2},  32'd0);
    check("rst state2", {30'd0, st2},    32'd0);
    check("rst ready0", {31'd0, ready0}, 32'd0);
    check("rst busy0",  {31'd0, busy0},  32'd0);
    rst = 1'b1;

    // Table-driven transactions on the LATENCY=2 instance.
    for (int i = 0; i < 12; i++) begin
      run_txn($sformatf("v%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
              vecs[i].scramble, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Store aborted by reset during the wait state.
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h20; wdata2 = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    check("abort in_wait", {30'd0, st2}, 32'd1);
    rst  = 1'b0;
    req2 = 1'b0;
    #1;
    check("abort busy",  {31'd0, busy2},  32'd0);
    check("abort ready", {31'd0, ready2}, 32'd0);
    check("abort state", {30'd0, st2},    32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("abort no_ready %0d", k), {31'd0, ready2}, 32'd0);
    end
    run_txn("abort reload", 1'b0, 32'h20, 32'h0, 1'b0, 32'h1234_5678, 1'b0);

    // LATENCY=0: store then loads with req held high throughout.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h55AA_55AA;
    @(posedge clk);
    @(negedge clk);
    check("l0 store ready", {31'd0, ready0}, 32'd1);
    check("l0 store err",   {31'd0, err0},   32'd0);
    check("l0 store rdata", rdata0,          32'd0);
    check("l0 store busy",  {31'd0, busy0},  32'd1);
    we0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        check($sformatf("l0 idle ready %0d", k), {31'd0, ready0}, 32'd0);
        check($sformatf("l0 idle busy %0d", k),  {31'd0, busy0},  32'd0);
      end else begin
        check($sformatf("l0 load ready %0d", k), {31'd0, ready0}, 32'd1);
        check($sformatf("l0 load busy %0d", k),  {31'd0, busy0},  32'd1);
        check($sformatf("l0 load rdata %0d", k), rdata0,          32'h55AA_55AA);
        check($sformatf("l0 load err %0d", k),   {31'd0, err0},   32'd0);
      end
    end
    req0 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
